// File: rtl/jb_xcvr_pkg.sv
// Framing constants and receive FSM encoding shared by the transceiver's
// serializer and deserializer, so TX and RX agree on width and sync word.
package jb_xcvr_pkg;

  localparam int         DEF_DATA_WIDTH = 8;
  localparam logic [7:0] DEF_SYNC_WORD  = 8'hA5;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/deserializer_sipo_out_reg.sv
// One-word holding register between the deserializer and the word consumer.
// Words offered while the register is full and not being drained are dropped.
module deser_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  offer,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  clr_overflow,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow
);

  // Handshake: data_out is transferred on any clk edge where out_valid=1 and
  // out_ready=1; out_valid never drops without such a transfer, and data_out
  // is stable while out_valid=1 and out_ready=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (offer) begin
        if (!out_valid || out_ready) begin
          data_out  <= word;
          out_valid <= 1'b1;
        end else begin
          overflow  <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/deserializer_sipo.sv
// LSB-first serial-to-parallel receiver: hunts bit-by-bit for the sync word,
// then frames every DATA_WIDTH valid bits into a word, discarding idle fill.
module deserializer_sipo
  import jb_xcvr_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = DEF_SYNC_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srl_in,
  input  logic                  srl_valid,
  input  logic                  resync,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  locked,
  output logic                  overflow
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0]   sh;
  logic [DATA_WIDTH-1:0]   cand;
  logic                    word_done;
  logic                    offer;

  // Newest bit enters at the MSB, so after W bits the first one sits at bit 0.
  assign cand      = {srl_in, sh[DATA_WIDTH-1:1]};
  assign word_done = (state == LOCKED) && srl_valid && (bit_cnt == CNT_LAST);
  assign offer     = word_done && (cand != SYNC_WORD) && !resync;
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HUNT;
      bit_cnt <= '0;
      sh      <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      if (srl_valid) begin
        sh <= cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    if (resync) begin
      state_nxt   = HUNT;
      bit_cnt_nxt = '0;
    end else if (srl_valid) begin
      case (state)
        HUNT: begin
          if (cand == SYNC_WORD) begin
            state_nxt   = LOCKED;
            bit_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          bit_cnt_nxt = word_done ? '0 : bit_cnt + CNT_ONE;
        end
        default: begin
          state_nxt   = HUNT;
          bit_cnt_nxt = '0;
        end
      endcase
    end
  end

  deser_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .offer        (offer),
    .word         (cand),
    .clr_overflow (resync),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow)
  );

endmodule

// File: tb/tb_deserializer_sipo.sv
// Directed and randomised checks of deserializer_sipo: lock hunting, framing,
// idle drop, gaps, backpressure/overflow, back-to-back accept, reset mid-word.
module tb_deserializer_sipo;

  localparam int         W    = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic         clk;
  logic         rst;
  logic         srl_in;
  logic         srl_valid;
  logic         resync;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         out_ready;
  logic         locked;
  logic         overflow;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  deserializer_sipo #(
    .DATA_WIDTH(W),
    .SYNC_WORD (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .srl_in    (srl_in),
    .srl_valid (srl_valid),
    .resync    (resync),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .overflow  (overflow)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the active edge.
  task automatic step(input logic v, input logic b);
    srl_valid = v;
    srl_in    = b;
    @(posedge clk);
    #1;
    srl_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) step(1'b1, w[i]);
  endtask

  task automatic send_word_gappy(input logic [W-1:0] w, input int max_gap);
    for (int i = 0; i < W; i++) begin
      step(1'b1, w[i]);
      for (int g = $urandom_range(0, max_gap); g > 0; g--)
        step(1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  // Scoreboard: every accepted word (valid && ready at the next edge) must
  // match the oldest expected word.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [W-1:0] exp;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk("sb_word", 32'(data_out), 32'(exp));
    end
  end

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] seq_bits;
    rst = 1'b1; srl_in = 1'b0; srl_valid = 1'b0; resync = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_data", 32'(data_out), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // Lock at a 3-bit offset
    out_ready = 1'b1;
    step(1, 1); step(1, 1); step(1, 0);
    for (int i = 0; i < W - 1; i++) step(1'b1, SYNC[i]);
    chk("lock_before_11th", 32'(locked), 0);
    step(1'b1, SYNC[W-1]);
    chk("lock_at_11th", 32'(locked), 1);
    chk("lock_no_word", 32'(out_valid), 0);

    // Word delivery, continuous bits
    exp_q.push_back(8'h3C);
    send_word(8'h3C);
    chk("w1_valid", 32'(out_valid), 1);
    chk("w1_data", 32'(data_out), 32'h3C);
    exp_q.push_back(8'h81);
    seq_bits = 8'h81;
    step(1'b1, seq_bits[0]);
    chk("w1_consumed", 32'(out_valid), 0);
    for (int i = 1; i < W; i++) step(1'b1, seq_bits[i]);
    chk("w2_valid", 32'(out_valid), 1);
    chk("w2_data", 32'(data_out), 32'h81);
    step(0, 0);
    chk("w2_consumed", 32'(out_valid), 0);

    // Idle drop, then a word with alternating gaps
    send_word(SYNC);
    chk("idle_dropped", 32'(out_valid), 0);
    exp_q.push_back(8'h5A);
    seq_bits = 8'h5A;
    for (int i = 0; i < W; i++) begin
      step(1'b1, seq_bits[i]);
      if (i != W - 1) step(1'b0, ~seq_bits[i]);
    end
    chk("gap_valid", 32'(out_valid), 1);
    chk("gap_data", 32'(data_out), 32'h5A);
    step(0, 0);

    // Backpressure and overflow
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_word(8'h11);
    send_word(8'h22);
    chk("bp_data_held", 32'(data_out), 32'h11);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_overflow", 32'(overflow), 1);
    out_ready = 1'b1;
    step(0, 0);
    out_ready = 1'b0;
    chk("bp_drained", 32'(out_valid), 0);
    chk("bp_overflow_sticky", 32'(overflow), 1);
    resync = 1'b1;
    step(0, 0);
    resync = 1'b0;
    chk("resync_overflow", 32'(overflow), 0);
    chk("resync_locked", 32'(locked), 0);

    // Back-to-back accept on the completing edge
    send_word(SYNC);
    chk("relock", 32'(locked), 1);
    exp_q.push_back(8'h33);
    send_word(8'h33);
    exp_q.push_back(8'h44);
    seq_bits = 8'h44;
    for (int i = 0; i < W - 1; i++) step(1'b1, seq_bits[i]);
    out_ready = 1'b1;
    step(1'b1, seq_bits[W-1]);
    out_ready = 1'b0;
    chk("b2b_data", 32'(data_out), 32'h44);
    chk("b2b_valid", 32'(out_valid), 1);
    chk("b2b_overflow", 32'(overflow), 0);
    out_ready = 1'b1;
    step(0, 0);

    // Reset mid-word, then relock and receive intact
    seq_bits = 8'h7E;
    for (int i = 0; i < 5; i++) step(1'b1, seq_bits[i]);
    rst = 1'b1;
    step(1'b1, seq_bits[5]);
    rst = 1'b0;
    chk("mid_rst_data", 32'(data_out), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    send_word(SYNC);
    chk("post_rst_lock", 32'(locked), 1);
    exp_q.push_back(8'h7E);
    send_word(8'h7E);
    chk("post_rst_data", 32'(data_out), 32'h7E);
    step(0, 0);

    // Random non-idle words with random gaps, consumer always ready
    for (int k = 0; k < 8; k++) begin
      w = W'($urandom_range(0, 255));
      if (w == SYNC) w = 8'h3C;
      exp_q.push_back(w);
      send_word_gappy(w, 3);
      if ($urandom_range(0, 1) == 1) send_word(SYNC);
    end
    repeat (2) step(0, 0);
    chk("sb_drain", 32'(exp_q.size()), 0);
    chk("final_overflow", 32'(overflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/deserializer_sipo.md
Name: deserializer_sipo

Overview:
- Receive-side counterpart of the transceiver's PISO serializer: takes the LSB-first serial bit stream, hunts for a sync word to find word boundaries, and reassembles DATA_WIDTH-bit words.
- Delivers words to the downstream consumer through a one-word valid/ready output register.
- Sits between the line interface (or a loopback of the serializer's serial output) and the receive-side word logic.

Parameters:
- DATA_WIDTH, 8, word width in bits; must be ≥ 2.
- SYNC_WORD, 8'hA5, alignment/idle pattern, width DATA_WIDTH; received LSB first.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- srl_in  input  1  serial data bit.
- srl_valid  input  1  srl_in is sampled on this clk edge only when srl_valid=1.
- resync  input  1  single-cycle pulse: drop lock and return to HUNT.
- data_out  output  DATA_WIDTH  received word; bit 0 is the first bit received.
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  consumer accepts data_out on an edge where out_valid=1.
- locked  output  1  word alignment established.
- overflow  output  1  sticky: a completed word was dropped because the output register was full.

Behaviour:
- Reset (rst=1 at an edge) overrides everything, including mid-word and mid-hunt. After reset:
  - data_out=0, out_valid=0, locked=0, overflow=0;
  - shift register=0, bit counter=0, state=HUNT.
- Shift: on each edge with srl_valid=1, sh <= {srl_in, sh[W-1:1]}. Call this next value cand.
- State HUNT (locked=0):
  - Each valid bit, compare cand with SYNC_WORD.
  - On a match, go to LOCKED with bit_cnt=0. The sync word itself is not emitted.
  - Hunting works at bit granularity, so any bit offset aligns.
- State LOCKED (locked=1):
  - bit_cnt counts valid bits 0..W-1 and wraps to 0 on the W-th bit.
  - On the W-th bit (bit_cnt=W-1 with srl_valid=1), cand is a complete word:
    - If cand == SYNC_WORD, it is idle fill and is discarded.
    - Otherwise cand is offered to the output register.
  - locked stays 1 until resync or rst.
- resync=1: state <= HUNT and bit_cnt <= 0. The shift register keeps shifting, and the current bit is still shifted in. resync also clears overflow. A word completing on the same edge is discarded. out_valid and data_out are unaffected, so a pending word stays deliverable.
- Output register:
  - A word offered while out_valid=0: data_out <= cand, out_valid <= 1.
  - Offered while out_valid=1 and out_ready=1 on the same edge: the old word is consumed, data_out <= cand, out_valid stays 1 (back-to-back, no bubble).
  - Offered while out_valid=1 and out_ready=0: the word is dropped, data_out is held, overflow <= 1 (sticky).
  - No offer and out_valid=1 and out_ready=1: out_valid <= 0; data_out is held (don't-care).
- Latency: out_valid rises on the clk edge that samples the last bit of the word, so it is visible the cycle after that bit's srl_valid cycle.
- srl_valid=0 gaps of any length freeze shift, count and state; the output handshake continues.
- Width rules: bit_cnt is $clog2(DATA_WIDTH) bits wide. The wrap compare is against DATA_WIDTH-1, so non-power-of-two widths must work.
- Throughput: up to 1 bit/clk, which gives 1 word per W clocks. The consumer must take a word within W cycles to avoid overflow.

Decomposition:
- Shared package jb_xcvr_pkg holds:
  - state enum {HUNT, LOCKED};
  - default DATA_WIDTH = 8 and SYNC_WORD = 8'hA5, shared with serializer_PISO so TX and RX agree on framing.
- One natural sub-module: deser_out_reg (one-word valid/ready holding register with overflow detect), parameterised by DATA_WIDTH.
- Shift/compare/count logic stays in the top module.

Test Plan:
- Lock at offset: after reset send bits 1,1,0 then A5 LSB-first (1,0,1,0,0,1,0,1) → locked=1 on the edge of the 11th valid bit; out_valid stays 0.
- Word delivery: after lock send 0x3C then 0x81, out_ready=1 constant, srl_valid=1 every clk → out_valid pulses one cycle after bits 8 and 16 of the payload, with data_out=0x3C then 0x81.
- Idle drop and gaps: after lock send A5, then 0x5A with srl_valid toggling 1,0,1,0 → only 0x5A is emitted; count resumes correctly across gaps.
- Backpressure/overflow: out_ready=0, send 0x11 then 0x22 → data_out stays 0x11, overflow=1. Then out_ready=1 for 1 cycle → out_valid=0, overflow still 1. Then resync → overflow=0, locked=0.
- Back-to-back accept: word 0x33 pending, out_ready=1 asserted exactly on the edge where 0x44 completes → data_out=0x44, out_valid stays 1, overflow=0.
- Reset mid-word: after lock with 5 bits of 0x7E shifted, pulse rst → all outputs 0, state HUNT. Then send A5 followed by 0x7E → 0x7E received intact.
